// File: rtl/processor_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : processor_sequencer
// Brief    : Accepts decoded opcodes over valid/ready, latches the op, issues
//            a one-cycle trigger to the processor selector, waits for done,
//            then holds off for a settle interval before the next accept.
//            Optional BUSY watchdog enabled by PROCESSOR_SEQUENCER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module processor_sequencer #(
    parameter int OP_BITS      = 4,
    parameter int SETTLE_CLKS  = 16,
    parameter int SETTLE_BITS  = 16,
    parameter int COUNT_BITS   = 16,
    parameter int TIMEOUT_CLKS = 2**20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [OP_BITS-1:0]    op_in,
    input  logic                  op_valid_in,
    output logic                  op_ready_out,
    input  logic                  halt_in,
    output logic [OP_BITS-1:0]    op_out,
    output logic                  trigger_out,
    input  logic                  done_in,
    output logic                  busy_out,
    output logic                  bad_op_out,
    output logic [COUNT_BITS-1:0] cmd_count_out,
    output logic                  fault_out
);

    // Motion opcodes understood by the selector (Opcode_p encoding).
    localparam logic [OP_BITS-1:0] c_OP_G00 = OP_BITS'(0);
    localparam logic [OP_BITS-1:0] c_OP_G01 = OP_BITS'(1);
    localparam logic [OP_BITS-1:0] c_OP_G02 = OP_BITS'(2);
    localparam logic [OP_BITS-1:0] c_OP_G03 = OP_BITS'(3);

    // Settle counter load value; a zero-length settle bypasses SETTLE.
    localparam logic [SETTLE_BITS-1:0] c_SETTLE_LOAD =
        (SETTLE_CLKS == 0) ? '0 : SETTLE_BITS'(SETTLE_CLKS - 1);

    // Parameter sanity checks at elaboration time.
    if ((SETTLE_CLKS >> SETTLE_BITS) != 0) begin : g_bad_settle_bits
        $error("processor_sequencer: SETTLE_CLKS does not fit in SETTLE_BITS");
    end
    if (TIMEOUT_CLKS < 1) begin : g_bad_timeout
        $error("processor_sequencer: TIMEOUT_CLKS must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_BUSY   = 3'd2,
`ifdef PROCESSOR_SEQUENCER_TIMEOUT_EN
        S_SETTLE = 3'd3,
        S_FAULT  = 3'd4
`else
        S_SETTLE = 3'd3
`endif
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [OP_BITS-1:0]      r_op;
    logic                    r_bad_op;
    logic [COUNT_BITS-1:0]   r_count;
    logic [SETTLE_BITS-1:0]  r_settle;
    logic                    w_accept;
    logic                    w_supported;
    logic                    w_complete;

    assign w_supported = (op_in == c_OP_G00) || (op_in == c_OP_G01) ||
                         (op_in == c_OP_G02) || (op_in == c_OP_G03);
    assign w_accept    = op_valid_in && op_ready_out;
    // done is only meaningful once the command has actually been issued.
    assign w_complete  = (r_state == S_BUSY) && done_in;

`ifdef PROCESSOR_SEQUENCER_TIMEOUT_EN
    localparam int c_WD_BITS = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [c_WD_BITS-1:0] c_WD_LAST = c_WD_BITS'(TIMEOUT_CLKS - 1);

    logic [c_WD_BITS-1:0] r_wd;
    logic                 w_wd_expired;

    assign w_wd_expired = (r_wd == c_WD_LAST);

    // Watchdog: cleared while issuing, counts every BUSY cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wd <= '0;
        end else if (r_state == S_ISSUE) begin
            r_wd <= '0;
        end else if (r_state == S_BUSY) begin
            r_wd <= r_wd + c_WD_BITS'(1);
        end
    end

    assign fault_out = (r_state == S_FAULT);
`else
    assign fault_out = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_supported) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_next = S_BUSY;
            end
            S_BUSY: begin
                if (done_in) begin
                    w_state_next = (SETTLE_CLKS == 0) ? S_IDLE : S_SETTLE;
                end
`ifdef PROCESSOR_SEQUENCER_TIMEOUT_EN
                else if (w_wd_expired) begin
                    w_state_next = S_FAULT;
                end
`endif
            end
            S_SETTLE: begin
                if (r_settle == '0) begin
                    w_state_next = S_IDLE;
                end
            end
`ifdef PROCESSOR_SEQUENCER_TIMEOUT_EN
            S_FAULT: begin
                w_state_next = S_FAULT;
            end
`endif
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Op latch: only a supported op replaces the selector's op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op <= c_OP_G00;
        end else if (w_accept && w_supported) begin
            r_op <= op_in;
        end
    end

    // Unsupported op consumed: flag it for exactly one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bad_op <= 1'b0;
        end else begin
            r_bad_op <= w_accept && !w_supported;
        end
    end

    // Completed-command counter, wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_complete) begin
            r_count <= r_count + COUNT_BITS'(1);
        end
    end

    // Settle counter: loaded on completion, counts down while settling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_settle <= '0;
        end else if (w_complete) begin
            r_settle <= c_SETTLE_LOAD;
        end else if ((r_state == S_SETTLE) && (r_settle != '0)) begin
            r_settle <= r_settle - SETTLE_BITS'(1);
        end
    end

    // Ready is gated by reset so nothing is taken while reset is held.
    assign op_ready_out  = reset && (r_state == S_IDLE) && !halt_in;
    assign op_out        = r_op;
    assign trigger_out   = (r_state == S_ISSUE);
    assign busy_out      = (r_state != S_IDLE);
    assign bad_op_out    = r_bad_op;
    assign cmd_count_out = r_count;

endmodule
`default_nettype wire

// File: tb/tb_processor_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_processor_sequencer
// Brief    : Self-checking bench for processor_sequencer using directed and
//            randomized command sequences against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_processor_sequencer;

    localparam int OP_BITS      = 4;
    localparam int SETTLE_CLKS  = 16;
    localparam int SETTLE_BITS  = 16;
    localparam int COUNT_BITS   = 4;
    localparam int TIMEOUT_CLKS = 100;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [OP_BITS-1:0]    op_in = '0;
    logic                  op_valid_in = 1'b0;
    logic                  halt_in = 1'b0;
    logic                  done_in = 1'b0;
    logic                  op_ready_out;
    logic [OP_BITS-1:0]    op_out;
    logic                  trigger_out;
    logic                  busy_out;
    logic                  bad_op_out;
    logic [COUNT_BITS-1:0] cmd_count_out;
    logic                  fault_out;

    processor_sequencer #(
        .OP_BITS      (OP_BITS),
        .SETTLE_CLKS  (SETTLE_CLKS),
        .SETTLE_BITS  (SETTLE_BITS),
        .COUNT_BITS   (COUNT_BITS),
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .op_in         (op_in),
        .op_valid_in   (op_valid_in),
        .op_ready_out  (op_ready_out),
        .halt_in       (halt_in),
        .op_out        (op_out),
        .trigger_out   (trigger_out),
        .done_in       (done_in),
        .busy_out      (busy_out),
        .bad_op_out    (bad_op_out),
        .cmd_count_out (cmd_count_out),
        .fault_out     (fault_out)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state: completed commands and last supported op.
    int                 exp_count = 0;
    logic [OP_BITS-1:0] exp_op    = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_motion(input logic [OP_BITS-1:0] op);
        return op < 4;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!op_ready_out && n < 100) begin
            tick();
            n++;
        end
        check("ready_wait", {31'd0, op_ready_out}, 32'd1);
    endtask

    // Entered in the ISSUE cycle; runs the command to the end of settle.
    task automatic finish_cmd(input int dly, input bit stray, input bit halt_mid);
        int n;
        bit retrig;
        if (stray) done_in = 1'b1;          // done during ISSUE must be ignored
        tick();
        done_in = 1'b0;
        check("busy_trigger_low", {31'd0, trigger_out}, 32'd0);
        check("busy_busy", {31'd0, busy_out}, 32'd1);
        check("busy_count_hold", 32'(cmd_count_out), 32'(exp_count));
        if (halt_mid) halt_in = 1'b1;
        repeat (dly - 1) tick();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        exp_count = (exp_count + 1) % (1 << COUNT_BITS);
        check("count_after_done", 32'(cmd_count_out), 32'(exp_count));
        n = 1;
        retrig = 1'b0;
        while (busy_out && n < 64) begin
            if (stray && n == 5) done_in = 1'b1;  // stray done while settling
            tick();
            done_in = 1'b0;
            if (trigger_out) retrig = 1'b1;
            n++;
        end
        check("settle_latency", 32'(n), 32'(SETTLE_CLKS + 1));
        check("no_trigger_in_settle", {31'd0, retrig}, 32'd0);
        check("ready_after_settle", {31'd0, op_ready_out}, {31'd0, !halt_in});
        check("op_out_stable", 32'(op_out), 32'(exp_op));
        check("count_after_settle", 32'(cmd_count_out), 32'(exp_count));
        if (halt_in) begin
            repeat (3) tick();
            check("halt_parks_ready", {31'd0, op_ready_out}, 32'd0);
            check("halt_parks_idle", {31'd0, busy_out}, 32'd0);
            halt_in = 1'b0;
            #1;
            check("halt_release_ready", {31'd0, op_ready_out}, 32'd1);
        end
    endtask

    task automatic run_cmd(input logic [OP_BITS-1:0] op, input int dly,
                           input bit stray, input bit halt_mid);
        wait_ready();
        op_in = op;
        op_valid_in = 1'b1;
        tick();
        op_valid_in = 1'b0;
        if (is_motion(op)) begin
            exp_op = op;
            check("trigger_after_accept", {31'd0, trigger_out}, 32'd1);
            check("op_out_latched", 32'(op_out), 32'(exp_op));
            check("issue_busy", {31'd0, busy_out}, 32'd1);
            finish_cmd(dly, stray, halt_mid);
        end else begin
            check("bad_op_pulse", {31'd0, bad_op_out}, 32'd1);
            check("bad_op_no_trigger", {31'd0, trigger_out}, 32'd0);
            check("bad_op_idle", {31'd0, busy_out}, 32'd0);
            check("bad_op_ready", {31'd0, op_ready_out}, 32'd1);
            check("bad_op_op_out", 32'(op_out), 32'(exp_op));
            check("bad_op_count", 32'(cmd_count_out), 32'(exp_count));
            tick();
            check("bad_op_one_cycle", {31'd0, bad_op_out}, 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        bit early_fault;
        // Reset state, with ready low while reset is held.
        tick();
        check("rst_ready", {31'd0, op_ready_out}, 32'd0);
        check("rst_trigger", {31'd0, trigger_out}, 32'd0);
        check("rst_busy", {31'd0, busy_out}, 32'd0);
        check("rst_bad_op", {31'd0, bad_op_out}, 32'd0);
        check("rst_count", 32'(cmd_count_out), 32'd0);
        check("rst_op_out", 32'(op_out), 32'd0);
        check("rst_fault", {31'd0, fault_out}, 32'd0);
        reset = 1'b1;
        tick();
        check("ready_after_reset", {31'd0, op_ready_out}, 32'd1);

        // Single G01 with done five BUSY cycles in.
        run_cmd(4'd1, 5, 1'b0, 1'b0);

        // G02 then G03 with valid held throughout.
        wait_ready();
        op_in = 4'd2;
        op_valid_in = 1'b1;
        tick();
        exp_op = 4'd2;
        check("b2b_first_trigger", {31'd0, trigger_out}, 32'd1);
        check("b2b_first_op", 32'(op_out), 32'd2);
        op_in = 4'd3;
        finish_cmd(3, 1'b0, 1'b0);
        tick();
        op_valid_in = 1'b0;
        exp_op = 4'd3;
        check("b2b_second_trigger", {31'd0, trigger_out}, 32'd1);
        check("b2b_second_op", 32'(op_out), 32'd3);
        finish_cmd(2, 1'b0, 1'b0);

        // Unsupported op, then halt during BUSY.
        run_cmd(4'd9, 1, 1'b0, 1'b0);
        run_cmd(4'd0, 3, 1'b0, 1'b1);

        // Valid together with halt in IDLE is not accepted.
        halt_in = 1'b1;
        op_in = 4'd1;
        op_valid_in = 1'b1;
        #1;
        check("halt_blocks_ready", {31'd0, op_ready_out}, 32'd0);
        tick();
        check("halt_no_accept_busy", {31'd0, busy_out}, 32'd0);
        check("halt_no_accept_trig", {31'd0, trigger_out}, 32'd0);
        op_valid_in = 1'b0;
        halt_in = 1'b0;

        // Randomized command stream.
        for (int i = 0; i < 30; i++) begin
            logic [OP_BITS-1:0] op;
            op = ($urandom_range(0, 3) == 0) ? OP_BITS'($urandom_range(4, 15))
                                             : OP_BITS'($urandom_range(0, 3));
            run_cmd(op, int'($urandom_range(1, 8)), bit'($urandom_range(0, 1)),
                    $urandom_range(0, 4) == 0);
        end

        // Async reset in the middle of BUSY.
        run_cmd(4'd1, 1, 1'b0, 1'b0);
        wait_ready();
        op_in = 4'd2;
        op_valid_in = 1'b1;
        tick();
        op_valid_in = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy_out}, 32'd0);
        check("midrst_count", 32'(cmd_count_out), 32'd0);
        check("midrst_op_out", 32'(op_out), 32'd0);
        check("midrst_ready", {31'd0, op_ready_out}, 32'd0);
        check("midrst_trigger", {31'd0, trigger_out}, 32'd0);
        exp_count = 0;
        exp_op = '0;
        tick();
        reset = 1'b1;
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        check("midrst_late_done", 32'(cmd_count_out), 32'd0);

        // BUSY with no done: watchdog (if built) or indefinite wait.
        wait_ready();
        op_in = 4'd1;
        op_valid_in = 1'b1;
        tick();
        op_valid_in = 1'b0;
        early_fault = 1'b0;
        for (int i = 1; i <= TIMEOUT_CLKS; i++) begin
            tick();
            if (fault_out !== 1'b0) early_fault = 1'b1;
        end
        check("no_early_fault", {31'd0, early_fault}, 32'd0);
        tick();
`ifdef PROCESSOR_SEQUENCER_TIMEOUT_EN
        check("wd_fault", {31'd0, fault_out}, 32'd1);
`else
        check("wd_fault", {31'd0, fault_out}, 32'd0);
`endif
        check("wd_busy", {31'd0, busy_out}, 32'd1);
        check("wd_ready", {31'd0, op_ready_out}, 32'd0);
        check("wd_trigger", {31'd0, trigger_out}, 32'd0);
        repeat (20) tick();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
`ifdef PROCESSOR_SEQUENCER_TIMEOUT_EN
        check("wd_sticky", {31'd0, fault_out}, 32'd1);
        check("wd_done_ignored", 32'(cmd_count_out), 32'd0);
`else
        check("late_done_counts", 32'(cmd_count_out), 32'd1);
`endif
        reset = 1'b0;
        #1;
        check("final_rst_fault", {31'd0, fault_out}, 32'd0);
        check("final_rst_busy", {31'd0, busy_out}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
